// File: rtl/instruction_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for instruction_loader.
// master: the loader (sinks bytes, drives the write port).
// slave:  the environment (byte source plus instruction memory).
interface instruction_loader_if #(
   parameter int ADDR_W = 16
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [15:0]       wdata;

   modport master (
      input  byte_valid, byte_data,
      output byte_ready, we, waddr, wdata
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, we, waddr, wdata
   );
endinterface

// File: rtl/instruction_loader.sv
// instruction_loader: fills the instruction memory from a big-endian byte
// stream, one 16-bit word per byte pair at consecutive addresses from 0, then
// raises ready to release instruction fetch.
// Optional feature macro: LOADER_CHECKSUM_EN -- after the last word, a 16-bit
// checksum (high byte first) is compared against the mod-2^16 sum of the
// loaded words; ready is withheld and error set on mismatch.
// Every output is a register; the FSM next-state logic also computes the
// next output values so that they are registered alongside the state.
module instruction_loader #(
   parameter int SIZE_IM = 32,
   parameter int ADDR_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     num_words,
   instruction_loader_if.master  bus,
   output logic                  busy,
   output logic                  ready,
   output logic                  error
);

   typedef enum logic [2:0] {
      IDLE, HI, LO, WRITE, DONE, CHK_HI, CHK_LO
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] len, len_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic [7:0]        hi, hi_nxt;
   logic [ADDR_W-1:0] waddr_nxt;
   logic [15:0]       wdata_nxt;
   logic              error_nxt;
   logic              acc;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0]       sum, sum_nxt;
   logic [7:0]        chk_hi, chk_hi_nxt;
`endif

   // byte_ready is registered and high only in byte-accepting states
   assign acc = bus.byte_valid && bus.byte_ready;

   // next-state and datapath: length check on start, byte assembly, counting
   always_comb begin
      state_nxt = state;
      len_nxt   = len;
      cnt_nxt   = cnt;
      hi_nxt    = hi;
      waddr_nxt = bus.waddr;
      wdata_nxt = bus.wdata;
      error_nxt = error;
`ifdef LOADER_CHECKSUM_EN
      sum_nxt    = sum;
      chk_hi_nxt = chk_hi;
`endif
      case (state)
         IDLE, DONE: begin
            if (start) begin
               if (num_words == '0 || num_words > ADDR_W'(SIZE_IM)) begin
                  error_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  error_nxt = 1'b0;
                  len_nxt   = num_words;
                  cnt_nxt   = '0;
                  state_nxt = HI;
`ifdef LOADER_CHECKSUM_EN
                  sum_nxt   = '0;
`endif
               end
            end
         end
         HI: begin
            if (acc) begin
               hi_nxt    = bus.byte_data;
               state_nxt = LO;
            end
         end
         LO: begin
            if (acc) begin
               waddr_nxt = cnt;
               wdata_nxt = {hi, bus.byte_data};
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            cnt_nxt = cnt + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
            sum_nxt = sum + bus.wdata;
            state_nxt = (cnt + ADDR_W'(1) == len) ? CHK_HI : HI;
`else
            state_nxt = (cnt + ADDR_W'(1) == len) ? DONE : HI;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         CHK_HI: begin
            if (acc) begin
               chk_hi_nxt = bus.byte_data;
               state_nxt  = CHK_LO;
            end
         end
         CHK_LO: begin
            if (acc) begin
               if ({chk_hi, bus.byte_data} == sum) begin
                  state_nxt = DONE;
               end else begin
                  error_nxt = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // state, datapath and registered outputs; reset discards any partial word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         len            <= '0;
         cnt            <= '0;
         hi             <= '0;
         bus.waddr      <= '0;
         bus.wdata      <= '0;
         bus.we         <= 1'b0;
         bus.byte_ready <= 1'b0;
         busy           <= 1'b0;
         ready          <= 1'b0;
         error          <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum            <= '0;
         chk_hi         <= '0;
`endif
      end else begin
         state          <= state_nxt;
         len            <= len_nxt;
         cnt            <= cnt_nxt;
         hi             <= hi_nxt;
         bus.waddr      <= waddr_nxt;
         bus.wdata      <= wdata_nxt;
         bus.we         <= (state_nxt == WRITE);
         bus.byte_ready <= (state_nxt == HI) || (state_nxt == LO) ||
                           (state_nxt == CHK_HI) || (state_nxt == CHK_LO);
         busy           <= (state_nxt == HI) || (state_nxt == LO) ||
                           (state_nxt == WRITE) ||
                           (state_nxt == CHK_HI) || (state_nxt == CHK_LO);
         ready          <= (state_nxt == DONE);
         error          <= error_nxt;
`ifdef LOADER_CHECKSUM_EN
         sum            <= sum_nxt;
         chk_hi         <= chk_hi_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader. Expected memory writes are
// pushed to a scoreboard queue as stimulus is prepared and popped whenever
// the DUT pulses we.
module tb_instruction_loader;
   localparam int SIZE_IM = 32;
   localparam int ADDR_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] num_words = '0;
   logic              busy, ready, error;

   instruction_loader_if #(.ADDR_W(ADDR_W)) bus_if();

   instruction_loader #(.SIZE_IM(SIZE_IM), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_words (num_words),
      .bus       (bus_if.master),
      .busy      (busy),
      .ready     (ready),
      .error     (error)
   );

   always #5 clk = ~clk;

   int                checks = 0;
   int                errors = 0;
   int                nwe = 0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [31:0]       exp_q[$];
   logic [15:0]       words[$];
   logic [7:0]        stream[$];

   // one clock; samples outputs 1 time unit after the edge, scoreboards writes
   task automatic cyc();
      logic [31:0] e;
      @(posedge clk);
      #1;
      if (bus_if.we === 1'b1) begin
         nwe++;
         last_addr = bus_if.waddr;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_we got addr=%0d data=%h, none expected", bus_if.waddr, bus_if.wdata);
         end else begin
            e = exp_q.pop_front();
            if ({bus_if.waddr, bus_if.wdata} !== e) begin
               errors++;
               $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                        bus_if.waddr, bus_if.wdata, e[31:16], e[15:0]);
            end
         end
         checks++;
         if (bus_if.byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL byte_ready_in_write got %b want 0", bus_if.byte_ready);
         end
      end
   endtask

   task automatic do_start(input int n);
      num_words = ADDR_W'(n);
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   // feed stream[] to the DUT; thr toggles byte_valid every cycle
   task automatic send(input bit thr);
      int idx, guard;
      bit ph, acc;
      idx = 0; guard = 0; ph = 1'b0;
      while (idx < stream.size() && guard < 2000) begin
         bus_if.byte_valid = thr ? ph : 1'b1;
         ph = ~ph;
         bus_if.byte_data = stream[idx];
         acc = bus_if.byte_valid && bus_if.byte_ready;
         cyc();
         guard++;
         if (acc) idx++;
      end
      bus_if.byte_valid = 1'b0;
      checks++;
      if (idx != stream.size()) begin
         errors++;
         $display("FAIL send_timeout got %0d bytes accepted want %0d", idx, stream.size());
      end
   endtask

   // build byte stream from words[] (plus checksum when enabled) and expectations
   task automatic load(input bit thr);
      logic [15:0] sum;
      logic [15:0] w;
      sum = '0;
      stream.delete();
      for (int i = 0; i < words.size(); i++) begin
         w = words[i];
         stream.push_back(w[15:8]);
         stream.push_back(w[7:0]);
         exp_q.push_back({16'(i), w});
         sum = sum + w;
      end
`ifdef LOADER_CHECKSUM_EN
      stream.push_back(sum[15:8]);
      stream.push_back(sum[7:0]);
`endif
      send(thr);
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (!(ready === 1'b1 || error === 1'b1) && g < 20) begin
         cyc();
         g++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_if.byte_valid = 1'b0;
      bus_if.byte_data = '0;
      cyc(); cyc();
      checks++;
      if ({bus_if.byte_ready, bus_if.we, bus_if.waddr, bus_if.wdata, busy, ready, error} !== '0) begin
         errors++;
         $display("FAIL reset_values got br=%b we=%b a=%h d=%h busy=%b rdy=%b err=%b want all 0",
                  bus_if.byte_ready, bus_if.we, bus_if.waddr, bus_if.wdata, busy, ready, error);
      end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_basic();
      int n0;
      n0 = nwe;
      words = '{16'h1234, 16'hABCD};
      do_start(2);
      load(1'b0);
`ifndef LOADER_CHECKSUM_EN
      cyc();
`endif
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_ready got ready=%b busy=%b want ready=1 busy=0", ready, busy);
      end
      checks++;
      if (nwe - n0 != 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_writes got %0d writes, %0d pending want 2, 0", nwe - n0, exp_q.size());
      end
   endtask

   task automatic test_throttle();
      int n0;
      n0 = nwe;
      words = '{16'hF000};
      do_start(1);
      load(1'b1);
      wait_done();
      checks++;
      if (nwe - n0 != 1 || ready !== 1'b1) begin
         errors++;
         $display("FAIL throttle got %0d writes ready=%b want 1 write ready=1", nwe - n0, ready);
      end
   endtask

   task automatic test_bad_len();
      int n0;
      n0 = nwe;
      do_start(0);
      checks++;
      if (error !== 1'b1 || ready !== 1'b0 || bus_if.byte_ready !== 1'b0) begin
         errors++;
         $display("FAIL bad_len0 got err=%b rdy=%b br=%b want 1 0 0", error, ready, bus_if.byte_ready);
      end
      do_start(SIZE_IM + 1);
      checks++;
      if (error !== 1'b1 || ready !== 1'b0 || bus_if.byte_ready !== 1'b0) begin
         errors++;
         $display("FAIL bad_len33 got err=%b rdy=%b br=%b want 1 0 0", error, ready, bus_if.byte_ready);
      end
      bus_if.byte_valid = 1'b1;
      repeat (3) cyc();
      bus_if.byte_valid = 1'b0;
      checks++;
      if (nwe != n0 || busy !== 1'b0 || error !== 1'b1) begin
         errors++;
         $display("FAIL bad_len_idle got %0d writes busy=%b err=%b want 0 writes busy=0 err=1", nwe - n0, busy, error);
      end
   endtask

   task automatic test_full();
      int n0;
      n0 = nwe;
      words.delete();
      for (int i = 0; i < SIZE_IM; i++) words.push_back(16'(i));
      do_start(SIZE_IM);
      checks++;
      if (error !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL full_start got err=%b busy=%b want 0 1", error, busy);
      end
      load(1'b0);
      wait_done();
      repeat (3) cyc();
      checks++;
      if (nwe - n0 != SIZE_IM || last_addr !== ADDR_W'(SIZE_IM - 1) || ready !== 1'b1) begin
         errors++;
         $display("FAIL full_load got %0d writes last=%0d rdy=%b want %0d writes last=%0d rdy=1",
                  nwe - n0, last_addr, ready, SIZE_IM, SIZE_IM - 1);
      end
      words = '{16'h5A5A};
      do_start(1);
      checks++;
      if (ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL restart got rdy=%b busy=%b want 0 1", ready, busy);
      end
      load(1'b0);
      wait_done();
      checks++;
      if (last_addr !== '0 || ready !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL restart_load got last=%0d rdy=%b pending=%0d want 0 1 0", last_addr, ready, exp_q.size());
      end
   endtask

   task automatic test_mid_reset();
      int n0;
      n0 = nwe;
      do_start(2);
      exp_q.push_back({16'd0, 16'h1111});
      stream = '{8'h11, 8'h11, 8'h22};
      send(1'b0);
      rst_n = 1'b0;
      bus_if.byte_valid = 1'b1;
      bus_if.byte_data = 8'h22;
      cyc();
      checks++;
      if ({bus_if.byte_ready, bus_if.we, bus_if.waddr, bus_if.wdata, busy, ready, error} !== '0) begin
         errors++;
         $display("FAIL mid_reset got br=%b we=%b a=%h d=%h busy=%b rdy=%b err=%b want all 0",
                  bus_if.byte_ready, bus_if.we, bus_if.waddr, bus_if.wdata, busy, ready, error);
      end
      cyc();
      rst_n = 1'b1;
      repeat (4) cyc();
      bus_if.byte_valid = 1'b0;
      checks++;
      if (nwe - n0 != 1 || exp_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_writes got %0d writes pending=%0d busy=%b want 1 0 0", nwe - n0, exp_q.size(), busy);
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      do_start(2);
      exp_q.push_back({16'd0, 16'h0001});
      exp_q.push_back({16'd1, 16'h0002});
      stream = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
      send(1'b0);
      wait_done();
      checks++;
      if (ready !== 1'b1 || error !== 1'b0) begin
         errors++;
         $display("FAIL csum_match got rdy=%b err=%b want 1 0", ready, error);
      end
      do_start(2);
      exp_q.push_back({16'd0, 16'h0001});
      exp_q.push_back({16'd1, 16'h0002});
      stream = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04};
      send(1'b0);
      wait_done();
      cyc();
      checks++;
      if (error !== 1'b1 || ready !== 1'b0 || busy !== 1'b0 || bus_if.byte_ready !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL csum_mismatch got err=%b rdy=%b busy=%b br=%b want 1 0 0 0", error, ready, busy, bus_if.byte_ready);
      end
   endtask
`endif

   initial begin
      bus_if.byte_valid = 1'b0;
      bus_if.byte_data = '0;
      test_reset();
      test_basic();
      test_throttle();
      test_bad_len();
      test_full();
      test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
